// File: rtl/mult_seq_n.sv
// mult_seq_n: iterative shift-add multiplier, WIDTH x WIDTH -> {hi,lo}, signed or unsigned.
// Signed operands are reduced to magnitudes, and the sign is applied to the product in the FIX state.
module mult_seq_n #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcnd, acc, mplr;
    logic               neg;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // The multiplier register doubles as the low half of the accumulator.
    always_comb begin
        sum  = {1'b0, acc} + (mplr[0] ? {1'b0, mcnd} : '0);
        prod = {acc, mplr};
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mcnd  <= '0;
            acc   <= '0;
            mplr  <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mcnd  <= (is_signed && a[WIDTH-1]) ? -a : a;
                    mplr  <= (is_signed && b[WIDTH-1]) ? -b : b;
                    acc   <= '0;
                    neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt   <= CW'(WIDTH - 1);
                    state <= RUN;
                end
                RUN: begin
                    acc  <= sum[WIDTH:1];
                    mplr <= {sum[0], mplr[WIDTH-1:1]};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    {hi, lo} <= neg ? -prod : prod;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_n.sv
// tb_mult_seq_n: directed and random checks of mult_seq_n (WIDTH 32 and 8) against an arithmetic model.
module tb_mult_seq_n;
    logic        clk = 1'b0;
    logic        rst_n, start, sg, start8, sg8;
    logic [31:0] a, b, hi, lo;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy, done, busy8, done8;
    logic [63:0] last;
    int          tests = 0, fails = 0;

    mult_seq_n #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .start(start), .is_signed(sg),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo));
    mult_seq_n #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return s ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return s ? 16'(sx * sy) : {8'b0, x} * {8'b0, y};
    endfunction

    // Issue one op, scramble inputs while busy, optionally re-pulse start at cycle 5.
    task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input string tag, input bit poke);
        int n;
        logic [63:0] e;
        e = ref32(x, y, s);
        @(negedge clk);
        a = x; b = y; sg = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = y ^ 32'h5a5a_a5a5; sg = ~s;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            start = poke && n == 5;
            @(posedge clk); #1;
            n++;
            if (n == 16) chk({tag, "_hold"}, {hi, lo}, last);
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_prod"}, {hi, lo}, e);
        last = e;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
        int n;
        @(negedge clk);
        a8 = x; b8 = y; sg8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~x; sg8 = ~s;
        n = 0;
        while (!done8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd9);
        chk({tag, "_prod"}, 64'({hi8, lo8}), 64'(ref8(x, y, s)));
    endtask

    initial begin
        int ndone;
        logic [31:0] x, y;
        rst_n = 1'b0; start = 1'b0; sg = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        last = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset32", {30'b0, busy, done, hi, lo}, 64'd0);
        chk("reset8", {46'b0, busy8, done8, hi8, lo8}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max", 1'b0);
        chk("u_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1 chk("done_drop", 64'(done), 64'd0);
        op32(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, "s_m3x5", 1'b0);
        chk("s_m3x5_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1m1", 1'b0);
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min2", 1'b0);
        chk("s_min2_lit", {hi, lo}, 64'h4000_0000_0000_0000);
        op32(32'h8000_0000, 32'h8000_0000, 1'b0, "u_min2", 1'b0);
        op32(32'h0000_0000, 32'h8765_4321, 1'b1, "s_zero", 1'b0);
        op32(32'h8000_0000, 32'h0000_0000, 1'b1, "s_negzero", 1'b0);
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "back2back", 1'b0);

        // A second start while busy must be ignored: same result, exactly one done.
        op32(32'h0001_0003, 32'h7FFF_FFFF, 1'b1, "poke", 1'b1);
        a = 32'h2; b = 32'h3;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1 ndone += int'(done); end
        chk("poke_single_done", 64'(ndone), 64'd0);

        // Reset during RUN drops the op and clears all outputs at once.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0000_0123; sg = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {30'b0, busy, done, hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        last = '0;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1 ndone += int'(done); end
        chk("rst_no_done", 64'(ndone), 64'd0);
        op32(32'h0000_BEEF, 32'hFFFF_0001, 1'b1, "after_rst", 1'b0);

        op8(8'h80, 8'h7F, 1'b1, "w8_s80x7f");
        chk("w8_lit", 64'({hi8, lo8}), 64'h0000_0000_0000_C080);
        op8(8'h80, 8'h80, 1'b1, "w8_min2");
        op8(8'hFF, 8'hFF, 1'b0, "w8_umax");
        for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), "w8_rand");

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) x = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 4) == 0) y = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0000_0001;
            op32(x, y, 1'($urandom), "rand", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
